// File: rtl/present_cipher_core_pkg.sv
// PRESENT cipher shared definitions: S-boxes, bit permutation, FSM encoding.
// Latency: n/a (constants and combinational helper functions only).
// Backpressure: n/a.
package present_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ENC,
      ST_DEC,
      ST_DONE
   } fsm_t;

   // Nibble n of each constant is the S-box output for input n.
   localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

   // Low bit of the 5-bit window that absorbs the round counter.
   localparam int KEY_XOR_LSB_80  = 15;
   localparam int KEY_XOR_LSB_128 = 62;

   function automatic int key_xor_lsb(input int key_w);
      return (key_w == 128) ? KEY_XOR_LSB_128 : KEY_XOR_LSB_80;
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      return INV_SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   // Bit j lands on (16*j) mod 63; bit 63 is a fixed point.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 63; j++) begin
         y[(16*j) % 63] = x[j];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 63; j++) begin
         y[j] = x[(16*j) % 63];
      end
      y[63] = x[63];
      return y;
   endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// Request/result handshake bundle for the PRESENT core (ready/valid both sides).
// Latency: n/a (wires only).
// Backpressure: in_ready gates requests, out_ready holds the result in place.
interface present_cipher_core_if #(
   parameter int KEY_W = 80
);
   logic             in_valid;
   logic             in_ready;
   logic             in_decrypt;
   logic [63:0]      in_data;
   logic [KEY_W-1:0] key;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_data;
   logic             busy;

   // Requester / result consumer side.
   modport master (
      output in_valid, in_decrypt, in_data, key, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   // Cipher core side.
   modport slave (
      input  in_valid, in_decrypt, in_data, key, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/present_cipher_core_key_sched.sv
// PRESENT key schedule step, forward or inverse, for 80- or 128-bit keys.
// Latency: combinational. Ports: key in, round counter in, inverse select, next_key out.
// Backpressure: n/a.
module present_key_sched
   import present_pkg::*;
#(
   parameter int KEY_W = 80
) (
   input  logic [KEY_W-1:0] key,
   input  logic [4:0]       round,
   input  logic             inverse,
   output logic [KEY_W-1:0] next_key
);

   localparam int XLSB = key_xor_lsb(KEY_W);

   logic [KEY_W-1:0] fwd;
   logic [KEY_W-1:0] bx;
   logic [KEY_W-1:0] bwd;

   always_comb begin
      // Forward: rotate left 61, substitute top nibble(s), fold in counter.
      fwd = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};
      fwd[KEY_W-1 -: 4] = sbox(fwd[KEY_W-1 -: 4]);
      if (KEY_W == 128) begin
         fwd[KEY_W-5 -: 4] = sbox(fwd[KEY_W-5 -: 4]);
      end
      fwd[XLSB +: 5] = fwd[XLSB +: 5] ^ round;

      // Inverse: same steps undone in reverse order, ending in rotate right 61.
      bx = key;
      bx[XLSB +: 5] = bx[XLSB +: 5] ^ round;
      bx[KEY_W-1 -: 4] = inv_sbox(bx[KEY_W-1 -: 4]);
      if (KEY_W == 128) begin
         bx[KEY_W-5 -: 4] = inv_sbox(bx[KEY_W-5 -: 4]);
      end
      bwd = {bx[60:0], bx[KEY_W-1:61]};

      next_key = inverse ? bwd : fwd;
   end

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT engine, 64-bit block, 80/128-bit key, encrypt or decrypt per block.
// Latency: result valid 31 edges (encrypt) or 62 edges (decrypt) after the accept edge.
// Backpressure: one block in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst (async, active high), bus (slave modport of present_cipher_core_if).
module present_cipher_core
   import present_pkg::*;
#(
   parameter int KEY_W  = 80,
   parameter int ROUNDS = 31
) (
   input  logic                  clk,
   input  logic                  rst,
   present_cipher_core_if.slave  bus
);

   if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
      $error("present_cipher_core: KEY_W must be 80 or 128");
   end
   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_cipher_core: ROUNDS must be within 1..31");
   end

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

   fsm_t             fsm;
   logic [63:0]      state_q;
   logic [KEY_W-1:0] key_q;
   logic [4:0]       cnt_q;
   logic [63:0]      out_data_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [KEY_W-1:0] ks_next;
   logic             ks_inverse;
   logic [63:0]      round_key;
   logic [63:0]      ks_next_top;
   logic [63:0]      enc_next;
   logic [63:0]      dec_next;
   logic             last_round;

   // Only the DEC walk runs the schedule backwards; KEYEXP and ENC go forward.
   assign ks_inverse = (fsm == ST_DEC);

   present_key_sched #(
      .KEY_W (KEY_W)
   ) u_key_sched (
      .key      (key_q),
      .round    (cnt_q),
      .inverse  (ks_inverse),
      .next_key (ks_next)
   );

   assign round_key   = key_q[KEY_W-1 -: 64];
   assign ks_next_top = ks_next[KEY_W-1 -: 64];
   assign enc_next    = p_layer(s_layer(state_q ^ round_key));
   // In DEC, ks_next is K(r) recovered from K(r+1) held in key_q.
   assign dec_next    = inv_s_layer(inv_p_layer(state_q)) ^ ks_next_top;
   assign last_round  = (cnt_q == LAST_ROUND);

   assign bus.in_ready  = (fsm == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm         <= ST_IDLE;
         state_q     <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  key_q   <= bus.key;
                  cnt_q   <= 5'd1;
                  state_q <= bus.in_data;
                  busy_q  <= 1'b1;
                  fsm     <= bus.in_decrypt ? ST_KEYEXP : ST_ENC;
               end
            end

            ST_ENC: begin
               state_q <= enc_next;
               key_q   <= ks_next;
               cnt_q   <= cnt_q + 5'd1;
               if (last_round) begin
                  // Final whitening with K(ROUNDS+1), which is ks_next here.
                  out_data_q  <= enc_next ^ ks_next_top;
                  out_valid_q <= 1'b1;
                  fsm         <= ST_DONE;
               end
            end

            ST_KEYEXP: begin
               // Run the schedule forward to K(ROUNDS+1) before decrypting.
               key_q <= ks_next;
               if (last_round) begin
                  state_q <= state_q ^ ks_next_top;
                  cnt_q   <= LAST_ROUND;
                  fsm     <= ST_DEC;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end

            ST_DEC: begin
               state_q <= dec_next;
               key_q   <= ks_next;
               cnt_q   <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  out_data_q  <= dec_next;
                  out_valid_q <= 1'b1;
                  fsm         <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  fsm         <= ST_IDLE;
               end
            end

            default: begin
               fsm <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: one 80-bit and one 128-bit instance, driven in turn.
// Reference: whole-block PRESENT model from a precomputed round-key table.
module tb_present_cipher_core;

   logic         clk;
   logic         rst;
   bit           sel;          // 0 = 80-bit instance, 1 = 128-bit instance
   logic         in_valid;
   logic         in_decrypt;
   logic [63:0]  in_data;
   logic [127:0] k_in;
   logic         out_ready;

   int checks;
   int failures;
   int cyc;

   present_cipher_core_if #(.KEY_W(80))  i80 ();
   present_cipher_core_if #(.KEY_W(128)) i128 ();

   assign i80.in_valid    = in_valid && !sel;
   assign i80.in_decrypt  = in_decrypt;
   assign i80.in_data     = in_data;
   assign i80.key         = k_in[79:0];
   assign i80.out_ready   = out_ready;
   assign i128.in_valid   = in_valid && sel;
   assign i128.in_decrypt = in_decrypt;
   assign i128.in_data    = in_data;
   assign i128.key        = k_in;
   assign i128.out_ready  = out_ready;

   present_cipher_core #(.KEY_W(80), .ROUNDS(31)) u_dut80 (
      .clk (clk),
      .rst (rst),
      .bus (i80)
   );

   present_cipher_core #(.KEY_W(128), .ROUNDS(31)) u_dut128 (
      .clk (clk),
      .rst (rst),
      .bus (i128)
   );

   logic [1:0]  ov_w, ir_w, bz_w;
   logic [63:0] od_w [2];
   assign ov_w     = {i128.out_valid, i80.out_valid};
   assign ir_w     = {i128.in_ready, i80.in_ready};
   assign bz_w     = {i128.busy, i80.busy};
   assign od_w[0]  = i80.out_data;
   assign od_w[1]  = i128.out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

   function automatic logic [3:0] m_inv_sb(input logic [3:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int j = 0; j < 16; j++) begin
         if (sb[j] == int'(v)) r = 4'(j);
      end
      return r;
   endfunction

   function automatic logic [63:0] m_sub(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = inv ? m_inv_sb(x[4*n +: 4]) : 4'(sb[x[4*n +: 4]]);
      end
      return y;
   endfunction

   // Bit i = 4a+b travels to 16b+a (bit 63 included).
   function automatic int m_pos(input int i);
      return (i % 4) * 16 + i / 4;
   endfunction

   function automatic logic [63:0] m_perm(input logic [63:0] x, input bit inv);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         if (inv) y[i] = x[m_pos(i)];
         else     y[m_pos(i)] = x[i];
      end
      return y;
   endfunction

   function automatic logic [63:0] present_model(input logic [127:0] k, input bit wide,
                                                 input logic [63:0] din, input bit dec);
      logic [63:0]  rk [1:32];
      logic [127:0] kr;
      logic [63:0]  s;
      kr = k;
      for (int i = 1; i <= 32; i++) begin
         if (wide) begin
            rk[i] = kr[127:64];
            kr = {kr[66:0], kr[127:67]};
            kr[127:124] = 4'(sb[kr[127:124]]);
            kr[123:120] = 4'(sb[kr[123:120]]);
            kr[66:62]   = kr[66:62] ^ 5'(i);
         end else begin
            rk[i] = kr[79:16];
            kr[79:0] = {kr[18:0], kr[79:19]};
            kr[79:76] = 4'(sb[kr[79:76]]);
            kr[19:15] = kr[19:15] ^ 5'(i);
         end
      end
      s = din;
      if (!dec) begin
         for (int r = 1; r <= 31; r++) s = m_perm(m_sub(s ^ rk[r], 1'b0), 1'b0);
         s = s ^ rk[32];
      end else begin
         s = s ^ rk[32];
         for (int r = 31; r >= 1; r--) s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[r];
      end
      return s;
   endfunction

   // Transaction-level timing model per instance.
   bit          m_pend [2];
   int          m_done [2];
   logic [63:0] m_exp  [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) m_pend[d] = 1'b0;
      end else begin
         cyc = cyc + 1;
         for (int d = 0; d < 2; d++) begin
            if (m_pend[d]) begin
               if ((cyc - 1) >= m_done[d] && out_ready) m_pend[d] = 1'b0;
            end else if (in_valid && (sel == (d == 1))) begin
               m_pend[d] = 1'b1;
               m_done[d] = cyc + (in_decrypt ? 62 : 31);
               m_exp[d]  = present_model((d == 1) ? k_in : {48'b0, k_in[79:0]}, d == 1,
                                         in_data, in_decrypt);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            string dn;
            bit    mv;
            dn = (d == 0) ? "w80" : "w128";
            mv = m_pend[d] && (cyc >= m_done[d]);
            chk({dn, " out_valid"}, 64'(ov_w[d]), 64'(mv));
            chk({dn, " in_ready"},  64'(ir_w[d]), 64'(!m_pend[d]));
            chk({dn, " busy"},      64'(bz_w[d]), 64'(m_pend[d]));
            if (mv) chk({dn, " out_data"}, od_w[d], m_exp[d]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_ov(input bit toggle);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (ov_w[sel]) begin
            ok = 1'b1;
            break;
         end
         if (toggle) begin
            k_in       = {$urandom, $urandom, $urandom, $urandom};
            in_data    = {$urandom, $urandom};
            in_decrypt = 1'($urandom);
         end
      end
      chk("result arrives within budget", 64'(ok), 64'd1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready after release", 64'(ir_w[sel]), 64'd1);
   endtask

   task automatic do_op(input bit s, input bit dec, input logic [127:0] k,
                        input logic [63:0] d, input bit toggle, input int hold,
                        output logic [63:0] res);
      int acc;
      @(posedge clk);
      #2;
      sel = s; in_decrypt = dec; k_in = k; in_data = d; in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      wait_ov(toggle);
      chk(dec ? "decrypt latency" : "encrypt latency", 64'(cyc - acc), dec ? 64'd62 : 64'd31);
      res = od_w[sel];
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk("held out_valid", 64'(ov_w[sel]), 64'd1);
         chk("held in_ready",  64'(ir_w[sel]), 64'd0);
         chk("held out_data",  od_w[sel], res);
      end
      release_result();
   endtask

   localparam logic [127:0] K80_ONES = {48'b0, {80{1'b1}}};
   localparam logic [127:0] K80_VEC  = {48'b0, 80'h0123456789abcdef0123};

   initial begin
      logic [63:0] r;
      checks = 0; failures = 0; cyc = 0;
      rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
      in_data = '0; k_in = '0; out_ready = 1'b0;

      // Pin the model against published vectors.
      chk("model enc80 zero", present_model('0, 1'b0, 64'h0, 1'b0), 64'h5579C1387B228445);
      chk("model enc80 ones", present_model(K80_ONES, 1'b0, '1, 1'b0), 64'h3333DCD3213210D2);
      chk("model dec80 ones", present_model(K80_ONES, 1'b0, 64'h3333DCD3213210D2, 1'b1), '1);
      chk("model enc128 zero", present_model('0, 1'b1, 64'h0, 1'b0), 64'h96DB702A2E6900AF);

      #3;
      chk("reset out_valid", 64'(ov_w), 64'd0);
      chk("reset busy",      64'(bz_w), 64'd0);
      #19 rst = 1'b0;
      @(negedge clk);
      chk("post-reset in_ready", 64'(ir_w), 64'd3);
      chk("post-reset out_data80",  od_w[0], 64'd0);
      chk("post-reset out_data128", od_w[1], 64'd0);

      do_op(1'b0, 1'b0, '0, 64'h0, 1'b0, 0, r);
      chk("enc80 zero", r, 64'h5579C1387B228445);
      do_op(1'b0, 1'b0, K80_ONES, '1, 1'b0, 20, r);
      chk("enc80 ones", r, 64'h3333DCD3213210D2);
      do_op(1'b0, 1'b1, K80_ONES, 64'h3333DCD3213210D2, 1'b0, 0, r);
      chk("dec80 ones", r, 64'hFFFFFFFFFFFFFFFF);

      do_op(1'b0, 1'b0, K80_VEC, 64'h1123456789abcdef, 1'b0, 0, r);
      do_op(1'b0, 1'b1, K80_VEC, r, 1'b0, 0, r);
      chk("roundtrip80", r, 64'h1123456789abcdef);

      do_op(1'b1, 1'b0, '0, 64'h0, 1'b0, 3, r);
      chk("enc128 zero", r, 64'h96DB702A2E6900AF);
      do_op(1'b1, 1'b1, '0, 64'h96DB702A2E6900AF, 1'b0, 0, r);
      chk("dec128 zero", r, 64'h0);

      // Second request held valid while the first block is in flight.
      @(posedge clk);
      #2 sel = 1'b0; in_decrypt = 1'b0; k_in = '0; in_data = '0; in_valid = 1'b1;
      @(posedge clk);
      #1 k_in = K80_ONES; in_data = '1;
      wait_ov(1'b0);
      chk("first of pair", od_w[0], 64'h5579C1387B228445);
      repeat (5) @(negedge clk);
      chk("pending req blocked", 64'(ir_w[0]), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("idle before second accept", 64'(bz_w[0]), 64'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("second accepted busy", 64'(bz_w[0]), 64'd1);
      wait_ov(1'b0);
      chk("second of pair", od_w[0], 64'h3333DCD3213210D2);
      release_result();

      // Inputs scrambled every cycle after accept.
      do_op(1'b0, 1'b0, K80_ONES, '1, 1'b1, 0, r);
      chk("toggle enc80", r, 64'h3333DCD3213210D2);
      do_op(1'b1, 1'b1, '0, 64'h96DB702A2E6900AF, 1'b1, 0, r);
      chk("toggle dec128", r, 64'h0);

      // Asynchronous reset part-way through a decrypt.
      @(posedge clk);
      #2 sel = 1'b0; in_decrypt = 1'b1; k_in = K80_ONES; in_data = 64'h3333DCD3213210D2;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy before reset", 64'(bz_w[0]), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("async rst out_valid", 64'(ov_w), 64'd0);
      chk("async rst busy",      64'(bz_w), 64'd0);
      chk("async rst out_data80",  od_w[0], 64'd0);
      chk("async rst out_data128", od_w[1], 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready after reset", 64'(ir_w), 64'd3);

      do_op(1'b0, 1'b0, '0, 64'h0, 1'b0, 0, r);
      chk("enc80 after reset", r, 64'h5579C1387B228445);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/present_cipher_core.md
Name: present_cipher_core

Overview:
- Iterative PRESENT block-cipher engine: 64-bit block, 80- or 128-bit key, encrypt and decrypt selectable per block.
- Successor to the fixed 80-bit decryption-only datapath.
- Adds parametrised key width, runtime mode select, ready/valid handshakes on both sides, and on-the-fly last-round-key derivation for decryption.
- Sits between the RISC-V accelerator interface and the memory-mapped result register.

Parameters:
- KEY_W, 80, key width; legal values 80 or 128. Any other value is an elaboration-time error.
- ROUNDS, 31, number of full rounds (round counter 1..ROUNDS).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  core can accept a request.
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled at accept.
- in_data  in  64  plaintext or ciphertext; sampled at accept.
- key  in  KEY_W  cipher key; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  64  result; stable while out_valid is high.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, any time, including mid-block):
  - FSM = IDLE; state, key and counter registers = 0.
  - out_data = 0, out_valid = 0, busy = 0, in_ready = 1 once reset deasserts.
  - Any in-flight block is discarded.
- Handshake:
  - Accept occurs on an edge with in_valid && in_ready.
  - in_ready = (FSM == IDLE).
  - Result is held with out_valid = 1 until an edge with out_ready. Then FSM returns to IDLE, in_ready rises the next cycle, and there is no back-to-back overlap.
- Round key = key register [KEY_W-1 : KEY_W-64].
- Key update, KEY_W = 80, round counter i:
  - Rotate left 61.
  - S-box bits [79:76].
  - bits [19:15] ^= i[4:0].
- Key update, KEY_W = 128:
  - Rotate left 61.
  - S-box bits [127:124] and [123:120].
  - bits [66:62] ^= i[4:0].
- Inverse key update is the exact inverse: undo the XOR, apply inverse S-box to the same nibbles, rotate right 61.
- pLayer: bit j moves to position (16*j) mod 63 for j < 63; bit 63 stays fixed.
- S-box: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0..F).
- FSM states: IDLE, KEYEXP, ENC, DEC, DONE.
- IDLE, on accept:
  - Load key register with key, cnt = 1.
  - Encrypt: state = in_data, next state ENC.
  - Decrypt: next state KEYEXP; hold in_data in the state register.
- ENC, each edge:
  - state <= P(S(state ^ RK)); key <= update(key, cnt); cnt++.
  - On the edge where cnt == ROUNDS: out_data <= P(S(state ^ RK)) ^ top64(update(key, ROUNDS)), and go to DONE.
  - Latency: out_valid rises ROUNDS (31) edges after the accept edge.
- KEYEXP, each edge:
  - key <= update(key, cnt); cnt++.
  - On the edge where cnt == ROUNDS: state <= state ^ top64(update(key, ROUNDS)), cnt = ROUNDS, go to DEC. The key register now holds K(ROUNDS+1).
- DEC, each edge, with the key register holding K(r+1) and r = cnt:
  - Kr = invupdate(key, r).
  - state <= invS(invP(state)) ^ top64(Kr); key <= Kr; cnt--.
  - On r == 1: out_data <= that value, go to DONE.
  - Latency: out_valid rises 2*ROUNDS (62) edges after accept.
- DONE: out_valid = 1, busy = 1; on out_ready go to IDLE, out_valid = 0. out_data keeps its last value.
- Inputs other than in_valid are ignored outside the accept edge; changing key or in_data mid-operation has no effect.
- Counter is 5 bits; ROUNDS must be at most 31 (elaboration check).

Decomposition:
- Package present_pkg holds:
  - SBOX and INV_SBOX constants.
  - p_layer and inv_p_layer functions.
  - FSM state enum.
  - Key-slice constants per KEY_W.
- One combinational sub-module, present_key_sched (parameter KEY_W; inputs key, round, inverse; output next key). It is instantiated once and its inverse input is driven by the FSM state.

Test Plan:
- Encrypt, KEY_W=80, key=0, data=0 -> out_data 5579C1387B228445; out_valid high exactly 31 cycles after accept.
- Encrypt, KEY_W=80, key all-F, data all-F -> 3333DCD3213210D2. Decrypt 3333DCD3213210D2 with the same key -> FFFFFFFFFFFFFFFF at 62-cycle latency.
- KEY_W=128, key=0, data=0:
  - Encrypt -> 96DB702A2E6900AF.
  - Decrypt back -> 0.
  - Also round-trip the fixed-block vector key=0123456789abcdef0123, data=1123456789abcdef (80-bit) and check decrypt(encrypt(x)) == x.
- Backpressure:
  - Hold out_ready=0 for 20 cycles -> out_data stable, out_valid=1, in_ready=0.
  - Then pulse out_ready -> in_ready=1 the next cycle.
  - A second in_valid held during busy is accepted only after that point.
- Mid-operation reset:
  - Assert rst at cycle 10 of a decrypt -> out_valid=0, busy=0, out_data=0 immediately, with no clock edge needed.
  - A fresh encrypt after reset gives the correct vector.
- Input change after accept: toggle key and in_data every cycle while busy -> result equals the value from the sampled inputs.
